// File: rtl/axi4l_reg_bank_if.sv
// Request/completion bus between the AXI4-Lite bridge and the register bank.
interface axi4l_reg_bank_if #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  logic [ADDR_WIDTH-1:0]   reg_addr;
  logic [DATA_WIDTH-1:0]   reg_wdata;
  logic [DATA_WIDTH/8-1:0] reg_wstrb;
  logic                    reg_wren;
  logic                    reg_rden;
  logic                    reg_req;
  logic                    reg_ack;
  logic [DATA_WIDTH-1:0]   reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_wstrb, reg_wren, reg_rden, reg_req,
    input  reg_ack, reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wstrb, reg_wren, reg_rden, reg_req,
    output reg_ack, reg_rdata
  );
endinterface

// File: rtl/axi4l_reg_bank.sv
// Register storage behind the AXI4-Lite bridge: RW / RO / W1C registers with
// a fixed-latency request/ack handshake and hardware set/readback hooks.
module axi4l_reg_bank #(
  parameter int                             NUM_REGS    = 16,
  parameter int                             DATA_WIDTH  = 32,
  parameter logic [NUM_REGS*2-1:0]          ACCESS_CTRL = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALS  = '0,
  parameter int                             ACK_DELAY   = 1
) (
  input  logic                           axi4l_aclk,
  input  logic                           axi4l_arstn,
  axi4l_reg_bank_if.slave                reg_if,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_data,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) begin
      m[8*b +: 8] = strb[b] ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  state_t          state_r, state_s;
  logic [3:0]      cnt_r, cnt_s;
  logic            cap_s;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [SW-1:0]   wstrb_r;
  logic            wren_r, rden_r;

  logic [AW-1:0]   eff_addr_s;
  logic [DW-1:0]   eff_wdata_s;
  logic [SW-1:0]   eff_wstrb_s;
  logic            eff_wr_s, eff_rd_s, eff_in_range_s;
  logic [DW-1:0]   wmask_s;
  logic            commit_s;
  logic [NUM_REGS-1:0] wr_hit_s;
  logic [DW-1:0]   rd_val_s [NUM_REGS];
  logic [DW-1:0]   rdata_s;

  logic            ack_r;
  logic [DW-1:0]   rdata_r;
  logic [NUM_REGS-1:0] wr_pulse_r;

  // Next-state logic: IDLE captures, WAIT counts down, ACK lasts one cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (reg_if.reg_req) begin
          cap_s = 1'b1;
          cnt_s = 4'(ACK_DELAY - 1);
          if (ACK_DELAY == 1) begin
            state_s = ST_ACK;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = ST_ACK;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ACK:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, delay counter and captured request fields.
  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
    if (axi4l_arstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      wren_r  <= 1'b0;
      rden_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (cap_s) begin
        addr_r  <= reg_if.reg_addr;
        wdata_r <= reg_if.reg_wdata;
        wstrb_r <= reg_if.reg_wstrb;
        wren_r  <= reg_if.reg_wren;
        rden_r  <= reg_if.reg_rden;
      end else begin
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
        wstrb_r <= wstrb_r;
        wren_r  <= wren_r;
        rden_r  <= rden_r;
      end
    end
  end

  // With a one-cycle delay the commit edge is the capture edge, so the live inputs apply.
  always_comb begin
    if (state_r == ST_IDLE) begin
      eff_addr_s  = reg_if.reg_addr;
      eff_wdata_s = reg_if.reg_wdata;
      eff_wstrb_s = reg_if.reg_wstrb;
      eff_wr_s    = reg_if.reg_wren;
      eff_rd_s    = reg_if.reg_rden & ~reg_if.reg_wren;
    end else begin
      eff_addr_s  = addr_r;
      eff_wdata_s = wdata_r;
      eff_wstrb_s = wstrb_r;
      eff_wr_s    = wren_r;
      eff_rd_s    = rden_r & ~wren_r;
    end
  end

  assign commit_s       = (state_s == ST_ACK);
  assign wmask_s        = byte_mask(eff_wstrb_s);
  assign eff_in_range_s = (32'(eff_addr_s) < 32'(NUM_REGS));

  // Write decode; out-of-range addresses match no register.
  always_comb begin
    wr_hit_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit_s[i] = commit_s & eff_wr_s & (32'(eff_addr_s) == 32'(i));
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [1:0] ACC = ACCESS_CTRL[2*gi +: 2];

    if (ACC == 2'b00) begin : g_rw
      localparam logic [DW-1:0] RST = RESET_VALS[DW*gi +: DW];
      logic [DW-1:0] store_r;
      logic          unused_s;

      // RW storage: strobed bytes take the write data.
      always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
          store_r <= RST;
        end else if (wr_hit_s[gi]) begin
          store_r <= (store_r & ~wmask_s) | (eff_wdata_s & wmask_s);
        end else begin
          store_r <= store_r;
        end
      end

      assign rd_val_s[gi]        = store_r;
      assign reg_q[DW*gi +: DW]  = store_r;
      assign unused_s = ^{hw_set[DW*gi +: DW], hw_ro_data[DW*gi +: DW]};
    end else if (ACC == 2'b10) begin : g_w1c
      localparam logic [DW-1:0] RST = RESET_VALS[DW*gi +: DW];
      logic [DW-1:0] store_r;
      logic [DW-1:0] clr_s;
      logic          unused_s;

      assign clr_s = wr_hit_s[gi] ? (eff_wdata_s & wmask_s) : '0;

      // W1C storage: clear applied first so a same-cycle hardware set wins.
      always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
          store_r <= RST;
        end else begin
          store_r <= (store_r & ~clr_s) | hw_set[DW*gi +: DW];
        end
      end

      assign rd_val_s[gi]        = store_r;
      assign reg_q[DW*gi +: DW]  = store_r;
      assign unused_s = ^hw_ro_data[DW*gi +: DW];
    end else begin : g_ro
      logic unused_s;
      assign rd_val_s[gi]        = hw_ro_data[DW*gi +: DW];
      assign reg_q[DW*gi +: DW]  = '0;
      assign unused_s = ^hw_set[DW*gi +: DW];
    end
  end

  // Read data: writes and no-op requests return zero.
  always_comb begin
    if (eff_wr_s) begin
      rdata_s = '0;
    end else if (eff_rd_s && eff_in_range_s) begin
      rdata_s = rd_val_s[eff_addr_s];
    end else begin
      rdata_s = '0;
    end
  end

  // Registered completion outputs; rdata holds between acks.
  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
    if (axi4l_arstn) begin
      ack_r      <= 1'b0;
      rdata_r    <= '0;
      wr_pulse_r <= '0;
    end else begin
      ack_r      <= commit_s;
      wr_pulse_r <= wr_hit_s;
      if (commit_s) begin
        rdata_r <= rdata_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign reg_if.reg_ack   = ack_r;
  assign reg_if.reg_rdata = rdata_r;
  assign wr_pulse         = wr_pulse_r;

endmodule

// File: tb/tb_axi4l_reg_bank.sv
// Randomized + directed bench for axi4l_reg_bank against a transaction-level model.
module tb_axi4l_reg_bank;
  localparam int NR = 12;
  localparam int DW = 32;
  localparam int AD = 4;
  // reg0/1 RW, reg2 W1C, reg3 RO, reg4 reserved, reg5 W1C, reg6..11 RW
  localparam logic [NR*2-1:0] ACC = 24'h000B60;

  function automatic logic [NR*DW-1:0] mk_rv();
    logic [NR*DW-1:0] v;
    v = '0;
    v[1*DW +: DW] = 32'h0000_00A5;
    v[4*DW +: DW] = 32'hDEAD_BEEF;
    v[5*DW +: DW] = 32'hFFFF_0000;
    v[6*DW +: DW] = 32'h1234_5678;
    return v;
  endfunction
  localparam logic [NR*DW-1:0] RV = mk_rv();

  logic clk = 1'b0;
  logic arstn;
  logic [NR*DW-1:0] hw_ro_data, hw_set, reg_q;
  logic [NR-1:0] wr_pulse;
  int n_checks = 0;
  int n_errors = 0;

  axi4l_reg_bank_if #(.NUM_REGS(NR), .DATA_WIDTH(DW)) bus ();

  axi4l_reg_bank #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ACCESS_CTRL(ACC),
    .RESET_VALS(RV), .ACK_DELAY(AD)
  ) dut (
    .axi4l_aclk(clk), .axi4l_arstn(arstn), .reg_if(bus),
    .hw_ro_data(hw_ro_data), .hw_set(hw_set), .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] acc_of(input int i);
    logic [NR*2-1:0] a;
    a = ACC;
    return a[2*i +: 2];
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_store [NR];
  bit            m_pend;
  int            m_acc_edge, edge_no;
  logic [3:0]    m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  bit            m_wr, m_rd;
  logic          e_ack;
  logic [DW-1:0] e_rdata;
  logic [NR-1:0] e_wp;

  task automatic m_reset();
    logic [NR*DW-1:0] rv;
    rv = RV;
    for (int i = 0; i < NR; i++)
      m_store[i] = (acc_of(i) == 2'b00 || acc_of(i) == 2'b10) ? rv[i*DW +: DW] : 32'h0;
    m_pend = 0; edge_no = 0; e_ack = 1'b0; e_rdata = '0; e_wp = '0;
  endtask

  task automatic m_step();
    logic [DW-1:0] nxt [NR];
    logic [DW-1:0] mask;
    edge_no++;
    // free only when no transaction is pending and the ack cycle has passed
    if (!m_pend && !e_ack && bus.reg_req) begin
      m_addr = bus.reg_addr; m_wdata = bus.reg_wdata; m_wstrb = bus.reg_wstrb;
      m_wr = bus.reg_wren; m_rd = bus.reg_rden && !bus.reg_wren;
      m_pend = 1; m_acc_edge = edge_no;
    end
    e_ack = 1'b0; e_wp = '0;
    for (int i = 0; i < NR; i++) nxt[i] = m_store[i];
    if (m_pend && edge_no == m_acc_edge + AD - 1) begin
      m_pend = 0; e_ack = 1'b1;
      mask = '0;
      for (int b = 0; b < 4; b++) if (m_wstrb[b]) mask[8*b +: 8] = 8'hFF;
      if (m_wr) begin
        e_rdata = '0;
        if (m_addr < NR) begin
          e_wp[m_addr] = 1'b1;
          if (acc_of(int'(m_addr)) == 2'b00)
            nxt[m_addr] = (m_store[m_addr] & ~mask) | (m_wdata & mask);
          else if (acc_of(int'(m_addr)) == 2'b10)
            nxt[m_addr] = m_store[m_addr] & ~(m_wdata & mask);
        end
      end else if (m_rd && m_addr < NR) begin
        if (acc_of(int'(m_addr)) == 2'b00 || acc_of(int'(m_addr)) == 2'b10)
          e_rdata = m_store[m_addr];
        else
          e_rdata = hw_ro_data[int'(m_addr)*DW +: DW];
      end else begin
        e_rdata = '0;
      end
    end
    for (int i = 0; i < NR; i++)
      if (acc_of(i) == 2'b10) nxt[i] = nxt[i] | hw_set[i*DW +: DW];
    for (int i = 0; i < NR; i++) m_store[i] = nxt[i];
  endtask

  function automatic logic [NR*DW-1:0] exp_q();
    logic [NR*DW-1:0] q;
    for (int i = 0; i < NR; i++) q[i*DW +: DW] = m_store[i];
    return q;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge arstn);
      if (arstn) m_reset();
      else m_step();
    end
  end

  // compare DUT outputs to the model every cycle
  initial begin
    forever begin
      @(negedge clk);
      chk("ack", bus.reg_ack, e_ack);
      chk("rdata", bus.reg_rdata, e_rdata);
      chk("wr_pulse", wr_pulse, e_wp);
      chk("reg_q", reg_q, exp_q());
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit wr, input bit rd, input logic [31:0] race,
                        output logic [31:0] rdata, output int lat,
                        output logic [NR-1:0] wp, output logic [NR*DW-1:0] q);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wstrb = s;
    bus.reg_wren = wr; bus.reg_rden = rd; bus.reg_req = 1'b1;
    lat = 0; rdata = '0; wp = '0; q = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      bus.reg_req = 1'b0;
      hw_set[2*DW +: DW] = (n == AD - 1) ? race : 32'h0;
      if (bus.reg_ack) begin
        lat = n; rdata = bus.reg_rdata; wp = wr_pulse; q = reg_q;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout addr=%0d actual=none expected=ack", a);
    end
  endtask

  logic [31:0] rd;
  int lat, acks, first;
  logic [NR-1:0] wp;
  logic [NR*DW-1:0] q;

  initial begin
    arstn = 1'b1;
    bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_wstrb = '0;
    bus.reg_wren = 1'b0; bus.reg_rden = 1'b0; bus.reg_req = 1'b0;
    hw_ro_data = '0; hw_set = '0;
    repeat (3) @(negedge clk);
    #2 arstn = 1'b0;

    chk("rst_q1", reg_q[1*DW +: DW], 32'h0000_00A5);
    chk("rst_q5", reg_q[5*DW +: DW], 32'hFFFF_0000);
    chk("rst_q4_reserved", reg_q[4*DW +: DW], 32'h0);

    do_req(4'd1, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("rst_read_lat", lat, AD);
    chk("rst_read_data", rd, 32'h0000_00A5);

    do_req(4'd0, 32'h1122_3344, 4'hF, 1, 0, 32'h0, rd, lat, wp, q);
    do_req(4'd0, 32'hAABB_CCDD, 4'b0101, 1, 0, 32'h0, rd, lat, wp, q);
    chk("rw_wr_pulse", wp, 12'h001);
    @(negedge clk);
    chk("rw_wr_pulse_drop", wr_pulse, 12'h000);
    do_req(4'd0, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("rw_strobe_read", rd, 32'h11BB_33DD);

    @(negedge clk); hw_set[2*DW +: DW] = 32'h0000_000F;
    @(negedge clk); hw_set[2*DW +: DW] = 32'h0;
    do_req(4'd2, 32'h0000_0003, 4'hF, 1, 0, 32'h0, rd, lat, wp, q);
    do_req(4'd2, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("w1c_clear", rd, 32'h0000_000C);
    do_req(4'd2, 32'h0000_0003, 4'hF, 1, 0, 32'h0000_0001, rd, lat, wp, q);
    chk("w1c_race_q", q[2*DW +: DW], 32'h0000_000D);
    do_req(4'd2, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("w1c_race_read", rd, 32'h0000_000D);

    hw_ro_data[3*DW +: DW] = 32'hCAFE_F00D;
    hw_ro_data[4*DW +: DW] = 32'h55AA_55AA;
    do_req(4'd3, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("ro_read", rd, 32'hCAFE_F00D);
    do_req(4'd4, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("reserved_read", rd, 32'h55AA_55AA);
    do_req(4'd3, 32'h0, 4'hF, 1, 0, 32'h0, rd, lat, wp, q);
    chk("ro_write_lat", lat, AD);
    chk("ro_write_pulse", wp, 12'h008);
    chk("ro_write_q", q[3*DW +: DW], 32'h0);
    chk("ro_write_rdata", rd, 32'h0);

    // busy: extra requests in WAIT (n=2) and in the ACK cycle (n=4) are dropped
    @(negedge clk);
    bus.reg_addr = 4'd1; bus.reg_wren = 1'b0; bus.reg_rden = 1'b1; bus.reg_req = 1'b1;
    acks = 0; first = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      bus.reg_req = (n == 2 || n == 4);
      if (n == 2) bus.reg_addr = 4'd0;
      if (bus.reg_ack) begin
        acks++;
        if (first == 0) first = n;
      end
    end
    bus.reg_req = 1'b0;
    chk("busy_ack_count", acks, 1);
    chk("busy_ack_lat", first, AD);
    do_req(4'd1, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    do_req(4'd6, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("b2b_lat", lat, AD);
    chk("b2b_data", rd, 32'h1234_5678);

    do_req(4'd13, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("oor_read", rd, 32'h0);
    do_req(4'd13, 32'hFFFF_FFFF, 4'hF, 1, 0, 32'h0, rd, lat, wp, q);
    chk("oor_write_lat", lat, AD);
    chk("oor_write_pulse", wp, 12'h000);
    do_req(4'd0, 32'hFFFF_FFFF, 4'hF, 1, 1, 32'h0, rd, lat, wp, q);
    chk("wr_rd_rdata", rd, 32'h0);
    chk("wr_rd_pulse", wp, 12'h001);
    do_req(4'd0, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    chk("wr_rd_stored", rd, 32'hFFFF_FFFF);
    do_req(4'd6, 32'h0, 4'h0, 0, 1, 32'h0, rd, lat, wp, q);
    do_req(4'd6, 32'h0, 4'hF, 0, 0, 32'h0, rd, lat, wp, q);
    chk("noop_lat", lat, AD);
    chk("noop_rdata", rd, 32'h0);
    chk("noop_pulse", wp, 12'h000);

    // reset while the request sits in WAIT
    @(negedge clk);
    bus.reg_addr = 4'd1; bus.reg_wdata = 32'h77; bus.reg_wstrb = 4'hF;
    bus.reg_wren = 1'b1; bus.reg_rden = 1'b0; bus.reg_req = 1'b1;
    @(negedge clk); bus.reg_req = 1'b0;
    @(negedge clk); #2 arstn = 1'b1;
    @(negedge clk); #2 arstn = 1'b0;
    acks = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.reg_ack) acks++;
    end
    chk("rst_mid_no_ack", acks, 0);
    chk("rst_mid_q0", reg_q[0 +: DW], 32'h0);
    chk("rst_mid_q1", reg_q[1*DW +: DW], 32'h0000_00A5);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.reg_req   = ($urandom_range(0, 2) == 0);
      bus.reg_addr  = 4'($urandom_range(0, 15));
      bus.reg_wdata = $urandom;
      bus.reg_wstrb = 4'($urandom_range(0, 15));
      bus.reg_wren  = 1'($urandom_range(0, 1));
      bus.reg_rden  = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) hw_set[i*DW +: DW] = $urandom & $urandom & $urandom;
      if (c % 8 == 0)
        for (int i = 0; i < NR; i++) hw_ro_data[i*DW +: DW] = $urandom;
    end
    @(negedge clk);
    bus.reg_req = 1'b0; hw_set = '0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi4l_reg_bank.md
Name: axi4l_reg_bank

Overview:
- Register storage stage directly downstream of the AXI4-Lite-to-register bridge (axi4l_regs).
- Consumes its reg_* request interface and returns reg_ack/reg_rdata.
- Holds NUM_REGS 32-bit registers with per-register access control: RW, RO or W1C.
- Exposes register contents, write strobes and hardware set/readback hooks to the fabric logic.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; 2..256.
- DATA_WIDTH, 32, register and bus data width; must be 32.
- ACCESS_CTRL, all zeros, NUM_REGS*2 bits packed; register i uses bits [2i+1:2i]. 00=RW, 01=RO, 10=W1C, 11=reserved (behaves as RO).
- RESET_VALS, all zeros, NUM_REGS*DATA_WIDTH bits packed; per-register reset value for RW and W1C registers.
- ACK_DELAY, 1, cycles from request capture to reg_ack; 1..15.

Ports:
- axi4l_aclk  in  1  clock.
- axi4l_arstn  in  1  reset, asynchronous, active-high.
- reg_addr  in  $clog2(NUM_REGS)  register index.
- reg_wdata  in  DATA_WIDTH  write data.
- reg_wstrb  in  DATA_WIDTH/8  byte write enables.
- reg_wren  in  1  request is a write.
- reg_rden  in  1  request is a read.
- reg_req  in  1  one-cycle request strobe.
- reg_ack  out  1  one-cycle completion strobe.
- reg_rdata  out  DATA_WIDTH  read data, valid while reg_ack=1.
- hw_ro_data  in  NUM_REGS*DATA_WIDTH  live values returned by RO registers.
- hw_set  in  NUM_REGS*DATA_WIDTH  per-bit set pulses for W1C registers.
- reg_q  out  NUM_REGS*DATA_WIDTH  current stored value of every register; RO slots read 0.
- wr_pulse  out  NUM_REGS  one-cycle strobe when register i accepts a write.

Behaviour:
- Reset (axi4l_arstn=1, asynchronous):
  - FSM to IDLE; reg_ack=0; reg_rdata=0; wr_pulse=0.
  - RW and W1C storage loads RESET_VALS; reg_q reflects RESET_VALS immediately.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On reg_req=1, capture addr, wdata, wstrb and operation. Load delay counter with ACK_DELAY-1.
  - Go to ACK if ACK_DELAY=1, else to WAIT.
- WAIT: decrement counter each cycle; go to ACK when counter reaches 1.
- ACK: reg_ack=1 for exactly one cycle, then go to IDLE.
- Latency: reg_ack asserts exactly ACK_DELAY cycles after the cycle reg_req was sampled high.
- Busy handling: reg_req seen in WAIT or ACK is ignored; no queueing, no ack.
- Back-to-back: the first cycle in which a new request is accepted is the cycle after reg_ack.
- Write effect: storage updates on the clock edge that asserts reg_ack; wr_pulse[addr]=1 in that same cycle.
  - RW: for each byte b with wstrb[b]=1, byte b takes wdata byte b.
  - W1C: for strobed bytes, each bit with wdata=1 clears.
  - RO/reserved: storage unchanged; wr_pulse still fires; reg_ack still given.
- Read data, registered, valid with reg_ack:
  - RW and W1C return stored value.
  - RO returns hw_ro_data slice sampled on the edge that asserts reg_ack.
  - reg_rdata is held between acks.
  - A write ack drives reg_rdata=0.
- hw_set: applies every cycle regardless of FSM state, W1C registers only; ignored for RW/RO.
  - Same bit set by hardware and cleared by software in one cycle: set wins, bit=1.
- Address >= NUM_REGS (non-power-of-2 NUM_REGS): read returns 0; write ignored, no wr_pulse; still acked.
- reg_wren and reg_rden both 1 with reg_req: treated as write.
- Neither set with reg_req: acked, no effect, rdata=0.
- Reset mid-transaction: request dropped, no ack issued after reset release.

Test Plan:
- Reset check: RESET_VALS[reg1]=0x0000_00A5; read reg 1 after reset -> reg_ack exactly ACK_DELAY cycles after reg_req, reg_rdata=0x0000_00A5.
- RW byte strobes: reg 0=0x1122_3344; write 0xAABB_CCDD with wstrb=0101 -> read returns 0x11BB_33DD; wr_pulse[0] one cycle high.
- W1C with set race:
  - Drive hw_set=0x0000_000F on reg 2 for one cycle, then write 0x0000_0003 -> read gives 0x0000_000C.
  - Repeat the write with hw_set bit 0 high in the ack cycle -> bit 0 stays 1.
- RO register: hw_ro_data reg 3=0xCAFE_F00D -> read returns 0xCAFE_F00D.
- RO write: write 0 to reg 3 -> reg_ack given, reg_q slot unchanged (0), wr_pulse[3]=1.
- Busy and latency, ACK_DELAY=4:
  - Second reg_req 2 cycles after the first -> only one reg_ack, 4 cycles after the first request.
  - Request immediately after ack -> accepted normally.
- Reset mid-operation: assert axi4l_arstn in WAIT, release -> no reg_ack, all registers back to RESET_VALS.
